counter10: RTL and testbench
============================

COUNTER10 -- requirements
Module: counter10

Interface
REQ-001 Parameter: MODULUS, default 10, count modulus; the count sequence is 0..MODULUS-1.
REQ-002 Parameter: WIDTH, default 4, bit width of cnt; SHALL satisfy 2**WIDTH >= MODULUS.
REQ-003 Port: clk, input, 1, single clock; all state SHALL update on the rising edge only.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: cnt, output, WIDTH, current count value, driven directly from a register.
REQ-006 Port order SHALL be clk, rst, cnt, so that positional instantiation counter10(clk, rst, cnt) works.
REQ-007 The block SHALL have exactly one clock domain (clk) and no other ports.

Function
REQ-008 On each rising clk edge with rst low, cnt SHALL increment by 1 when cnt < MODULUS-1.
REQ-009 On a rising clk edge with rst low and cnt == MODULUS-1 (9), cnt SHALL wrap to 0 on that same edge.
REQ-010 Latency: the effect of a clock edge SHALL be visible on cnt immediately after that edge, with zero added pipeline delay.
REQ-011 The sequence with default parameters SHALL be 0,1,2,...,9,0,1,... with no skipped or repeated values.
REQ-012 Illegal state recovery: if cnt >= MODULUS (unreachable in normal operation), the next rising edge SHALL load 0.
REQ-013 Arithmetic SHALL be unsigned and WIDTH bits wide; the comparison to MODULUS-1 SHALL take precedence over the increment.
REQ-014 cnt SHALL be glitch-free, with no combinational path from rst or clk to cnt other than the register itself.

Reset
REQ-015 While rst is high, cnt SHALL be 0, independent of clk.
REQ-016 Assertion of rst SHALL clear cnt asynchronously, without waiting for a clock edge.
REQ-017 Reset mid-count (for example at cnt == 6) SHALL force cnt to 0 immediately.
REQ-018 Reset SHALL take precedence over counting when rst and a clk edge coincide.
REQ-019 After rst deasserts, the first rising clk edge SHALL produce cnt == 1.
REQ-020 The power-up value of cnt SHALL be defined only by reset; no initial-value dependence is allowed.

Structure
REQ-021 Shared package counter10_pkg SHALL hold the constants COUNT_MODULUS (10), COUNT_WIDTH (4) and COUNT_MAX (9).
REQ-022 The block SHALL be a single module containing one register process with asynchronous reset and one next-state expression; no sub-module.
REQ-023 Next-state logic SHALL be purely combinational and fully specified, with no inferred latches.

Verification
REQ-024 Scenario 1: assert rst for 250 ns, then release it, and apply 10 clk edges (period 1000 ns) -> cnt SHALL read 1,2,...,9,0.
REQ-025 Scenario 2: count from reset release for 15 edges -> cnt SHALL read 1..9,0,1,2,3,4,5, confirming wrap and continuation.
REQ-026 Scenario 3: assert rst asynchronously mid-period when cnt == 6 -> cnt SHALL be 0 before the next clk edge and remain 0 while rst is high.
REQ-027 Scenario 4: hold rst high across 5 clk edges -> cnt SHALL remain 0 throughout.
REQ-028 Scenario 5: force the internal register to 12 and then release it with rst low -> cnt SHALL be 0 after the next edge and 1 after the following edge.
REQ-029 Bench SHALL check cnt against a reference model ((prev+1) mod 10) on every edge, dump a waveform file and log clk, rst and cnt on every change.

Source files
------------

// File: rtl/counter10_pkg.sv
// ---------------------------------------------------------------------------
// counter10_pkg
// Purpose : Shared constants for the modulo-10 counter block.
// Contents: COUNT_MODULUS - number of states in the count sequence
//           COUNT_WIDTH   - bit width of the count register
//           COUNT_MAX     - terminal count value (last value before wrap)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package counter10_pkg;

  localparam int COUNT_MODULUS = 10;
  localparam int COUNT_WIDTH   = 4;
  localparam int COUNT_MAX     = COUNT_MODULUS - 1;

endpackage : counter10_pkg

// File: rtl/counter10.sv
// ---------------------------------------------------------------------------
// counter10
// Purpose : Free-running modulo-MODULUS up counter (0..MODULUS-1, wrap to 0)
//           with asynchronous active-high reset and recovery from any value
//           outside the legal range.
// Params  : MODULUS - count modulus (default 10)
//           WIDTH   - width of cnt, 2**WIDTH must be >= MODULUS (default 4)
// Ports   : clk - rising-edge clock, the only clock domain
//           rst - asynchronous active-high reset, clears cnt to 0
//           cnt - current count, driven straight from the state register
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module counter10
  import counter10_pkg::*;
#(
  parameter int MODULUS = COUNT_MODULUS,
  parameter int WIDTH   = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cnt
);

  // Terminal count expressed at the register width so the compare is
  // unsigned and width-matched.
  localparam logic [WIDTH-1:0] LP_CNT_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;

  // A single ">=" compare covers both the normal wrap at the terminal count
  // and recovery from unreachable values above it; it is evaluated before
  // the increment so the increment can never overflow into an illegal value.
  always_comb begin
    w_cnt_next = '0;
    if (r_cnt < LP_CNT_MAX) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign cnt = r_cnt;

endmodule : counter10

// File: tb/tb_counter10.sv
// ---------------------------------------------------------------------------
// tb_counter10
// Purpose : Self-checking bench for counter10. A behavioural model tracks
//           the expected count as plain modulo arithmetic; directed
//           scenarios cover reset, wrap, asynchronous mid-count reset,
//           reset held across edges and illegal-state recovery, followed by
//           randomized asynchronous reset pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_counter10;

  import counter10_pkg::*;

  localparam int CLK_HALF = 500;  // 1000 ns period

  logic       clk;
  logic       rst;
  logic [3:0] cnt;

  int n_cmp;
  int n_err;
  int model_cnt;

  counter10 dut (
    .clk (clk),
    .rst (rst),
    .cnt (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: cnt=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one rising edge: reset wins, out-of-range values
  // recover to 0, otherwise count modulo COUNT_MODULUS.
  function automatic int model_step(input int prev, input logic r);
    if (r) return 0;
    if (prev >= COUNT_MODULUS) return 0;
    return (prev + 1) % COUNT_MODULUS;
  endfunction

  // Wait for the next rising edge, advance the model and compare just after.
  task automatic edge_check(input string tag);
    @(posedge clk);
    #1;
    model_cnt = model_step(model_cnt, rst);
    $display("t=%0t rst=%0b cnt=%0d model=%0d [%s]", $time, rst, cnt, model_cnt, tag);
    check_val(tag, int'(cnt), model_cnt);
  endtask

  initial begin
    int d;
    logic rst_new;

    n_cmp     = 0;
    n_err     = 0;
    model_cnt = 0;
    rst       = 1'b0;

    // Scenario 1/2: 250 ns of reset, then 15 edges of counting with wrap.
    #10;
    rst = 1'b1;
    #100;
    check_val("reset_state", int'(cnt), 0);
    #150;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      edge_check("count_wrap");
    end

    // Scenario 3: run to 6, then reset mid-period, before any edge.
    while (model_cnt != 6) begin
      edge_check("run_to_6");
    end
    @(negedge clk);
    #100;
    rst = 1'b1;
    #1;
    check_val("async_rst_mid", int'(cnt), 0);

    // Scenario 4: reset held across 5 edges.
    for (int i = 0; i < 5; i++) begin
      edge_check("rst_held");
    end
    @(negedge clk);
    rst = 1'b0;
    edge_check("first_after_rst");

    // Scenario 5: illegal value 12 must recover to 0, then count on.
    @(negedge clk);
    force dut.r_cnt = 4'd12;
    #1;
    release dut.r_cnt;
    #1;
    check_val("forced_illegal", int'(cnt), 12);
    model_cnt = 12;
    edge_check("illegal_recover");
    edge_check("after_recover");

    // Randomized asynchronous reset pulses at random points in the period.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      d = int'($urandom_range(1, 400));
      #d;
      rst_new = ($urandom_range(0, 7) == 0);
      if (rst_new && !rst) begin
        rst = 1'b1;
        #1;
        check_val("rand_async_rst", int'(cnt), 0);
      end else begin
        rst = rst_new;
      end
      edge_check("rand_edge");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_counter10
